// File: rtl/aes_pkg.sv
// Shared AES constants, round constants, FSM state type and round-key layout helpers.
// AES_KEY_REVERSE_EN adds the EXPAND state used to fill the reverse-order key buffer.
package aes_pkg;

    localparam int N = 4;
    localparam int Nr = N + 6;
    localparam int KEY_BITS = N * N * 8;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

`ifdef AES_KEY_REVERSE_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_STREAM = 2'd2
    } key_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd2
    } key_state_t;
`endif

    // Column word c of a flat key: row 0 lands in the most significant byte.
    function automatic logic [31:0] get_word(input logic [KEY_BITS-1:0] key, input int c);
        logic [31:0] w;
        w = '0;
        for (int r = 0; r < N; r++) begin
            w[31-8*r -: 8] = key[8*(r*N+c) +: 8];
        end
        return w;
    endfunction

    function automatic logic [KEY_BITS-1:0] set_words(input logic [31:0] w0,
                                                      input logic [31:0] w1,
                                                      input logic [31:0] w2,
                                                      input logic [31:0] w3);
        logic [KEY_BITS-1:0] key;
        logic [31:0]         w [0:3];
        w[0] = w0;
        w[1] = w1;
        w[2] = w2;
        w[3] = w3;
        key  = '0;
        for (int c = 0; c < N; c++) begin
            for (int r = 0; r < N; r++) begin
                key[8*(r*N+c) +: 8] = w[c][31-8*r -: 8];
            end
        end
        return key;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box; one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule streaming one round key per rk handshake.
// AES_KEY_REVERSE_EN adds an 11-entry key buffer so decrypt keys stream round 10 down to 0.
//
// state     | meaning
// ST_IDLE   | waiting for a cipher key, start_ready high
// ST_EXPAND | (reverse build only) computing rounds 1..10 into the key buffer
// ST_STREAM | rk valid, advancing one round per handshake
module aes_key_expand #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [N*N*8-1:0]     key_in,
    input  logic                 decrypt,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic [N*N*8-1:0]     rk,
    output logic [3:0]           rk_round,
    output logic                 rk_last
);

    import aes_pkg::*;

    localparam int KeySize = N * N * 8;
    localparam logic [3:0] LAST_ROUND = 4'(Nr);

    key_state_t state, state_nx;

    logic [31:0]        w0, w1, w2, w3;
    logic [31:0]        rot_w3, sub_w3, temp;
    logic [31:0]        n0, n1, n2, n3;
    logic [7:0]         rcon_sel;
    logic [KeySize-1:0] next_key;
    logic               accept;
    logic               last_rnd;

    assign w0 = get_word(rk, 0);
    assign w1 = get_word(rk, 1);
    assign w2 = get_word(rk, 2);
    assign w3 = get_word(rk, 3);

    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .din  (rot_w3[31-8*i -: 8]),
            .dout (sub_w3[31-8*i -: 8])
        );
    end

    // rk_round reaches 10 only once the forward chain is done, so RCON is never read there.
    assign rcon_sel = (rk_round < LAST_ROUND) ? RCON[rk_round] : 8'h00;
    assign temp     = sub_w3 ^ {rcon_sel, 24'h0};
    assign n0       = w0 ^ temp;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = set_words(n0, n1, n2, n3);

    assign start_ready = (state == ST_IDLE) && !rst;
    assign rk_valid    = (state == ST_STREAM);
    assign accept      = start_valid && start_ready;

`ifdef AES_KEY_REVERSE_EN
    logic               rev;
    logic [KeySize-1:0] kbuf [0:10];

    assign last_rnd = rev ? (rk_round == 4'd0) : (rk_round == LAST_ROUND);
`else
    logic unused_decrypt;

    assign unused_decrypt = decrypt;
    assign last_rnd       = (rk_round == LAST_ROUND);
`endif

    assign rk_last = rk_valid && last_rnd;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef AES_KEY_REVERSE_EN
                    state_nx = decrypt ? ST_EXPAND : ST_STREAM;
`else
                    state_nx = ST_STREAM;
`endif
                end
            end
`ifdef AES_KEY_REVERSE_EN
            ST_EXPAND: begin
                if (rk_round == LAST_ROUND - 4'd1) begin
                    state_nx = ST_STREAM;
                end
            end
`endif
            ST_STREAM: begin
                if (rk_ready && last_rnd) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rk       <= '0;
            rk_round <= 4'd0;
`ifdef AES_KEY_REVERSE_EN
            rev      <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rk       <= key_in;
                        rk_round <= 4'd0;
`ifdef AES_KEY_REVERSE_EN
                        rev      <= decrypt;
`endif
                    end
                end
`ifdef AES_KEY_REVERSE_EN
                ST_EXPAND: begin
                    rk       <= next_key;
                    rk_round <= rk_round + 4'd1;
                end
`endif
                ST_STREAM: begin
`ifdef AES_KEY_REVERSE_EN
                    if (rk_ready && rev && (rk_round != 4'd0)) begin
                        rk       <= kbuf[rk_round - 4'd1];
                        rk_round <= rk_round - 4'd1;
                    end else if (rk_ready && !rev && (rk_round != LAST_ROUND)) begin
                        rk       <= next_key;
                        rk_round <= rk_round + 4'd1;
                    end
`else
                    if (rk_ready && (rk_round != LAST_ROUND)) begin
                        rk       <= next_key;
                        rk_round <= rk_round + 4'd1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef AES_KEY_REVERSE_EN
    // Buffer holds no control state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                kbuf[0] <= key_in;
            end else if (state == ST_EXPAND) begin
                kbuf[rk_round + 4'd1] <= next_key;
            end
        end
    end
`endif

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key schedule that turns one cipher key into the eleven round keys consumed by the round-key XOR stage, streaming one round key per handshake. It sits directly upstream of the add-round-key stage and emits each round key in the identical flat byte layout that stage XORs into the state. One round key is computed per cycle from the previously registered key with a 4-S-box datapath; no full key table is kept unless reverse streaming is compiled in.

## Interface
- `N`, default 4: state dimension; only 4 (AES-128) is supported. Derived localparams: `KeySize = N*N*8` (128); `Nr = N + 6` (10 rounds).
- `clk  in  1`: single clock; all logic is posedge.
- `rst  in  1`: reset is synchronous and active-high.
- `start_valid  in  1`: a cipher key is offered on `key_in`.
- `start_ready  out  1`: high only in IDLE. Key accepted on a cycle where `start_valid && start_ready`.
- `key_in  in  KeySize`: cipher key, sampled only on accept.
- `decrypt  in  1`: sampled on accept. Honoured only with the macro; ignored otherwise.
- `rk_valid  out  1`: `rk` holds a valid round key.
- `rk_ready  in  1`: consumer accepts `rk` on a cycle where `rk_valid && rk_ready`.
- `rk  out  KeySize`: round key. Byte at bits `8*(r*N+c)+:8` is row r of column word c. Row 0 is the FIPS most-significant byte of word w[c].
- `rk_round  out  4`: index 0..10 of the key currently on `rk`.
- `rk_last  out  1`: high with the final key of the sequence (round 10 forward, round 0 reverse).

## Operation
- FSM states: IDLE, EXPAND (macro only), STREAM.
- IDLE: `start_ready=1`. On accept, go to STREAM (forward) or EXPAND (reverse). Load `rk <= key_in` and `rk_round <= 0`.
- Forward STREAM: on each rk handshake with `rk_round < 10`, load `rk` with next_key(`rk`, RCON[`rk_round`]) and increment `rk_round`.
  - next_key: temp = SubWord(RotWord(w3)) ^ {rcon,24'h0}. Then w0' = w0 ^ temp, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'.
  - The handshake on round 10 returns to IDLE.
- `rk`, `rk_round` and `rk_last` are held stable while `rk_valid && !rk_ready`.
- `start_valid` outside IDLE is ignored and not queued. `key_in` and `decrypt` are don't-care except on the accept cycle.
- `rk_last = (rk_round == 10)` forward, `(rk_round == 0)` reverse.
- `rst` at any point (mid-expand, mid-stream, or under backpressure) aborts the sequence. Nothing resumes afterwards.
- Reset values: state IDLE, `rk_valid=0`, `rk=0`, `rk_round=0`, `rk_last=0`. `start_ready=1` from the first cycle after the reset edge; it is 0 while `rst` is high.

## Timing
- Key accepted at edge t: `rk_valid=1` with round 0 from t+1, forward mode.
- Back-to-back: if round k is handshaken at edge t, round k+1 is on `rk` from t+1. `rk_valid` stays high with no bubbles, so a full forward sequence takes 11 cycles with `rk_ready` held at 1.
- Final handshake at edge t: `rk_valid=0` and `start_ready=1` from t+1. A new key may be accepted at t+1.
- Reverse mode: EXPAND occupies edges t+1..t+10, with `rk_valid=0` throughout. Round 10 appears at t+11, then rounds 9..0 follow one per handshake.

## Configuration
- `AES_KEY_REVERSE_EN` defined:
  - adds an 11-entry × 128-bit key buffer and the EXPAND state;
  - `decrypt=1` on accept fills the buffer, then streams rounds 10 down to 0 from the buffer;
  - `decrypt=0` behaves as forward mode.
- Not defined: no buffer and no EXPAND state. `decrypt` is ignored and the block is forward-only.

## Structure
- Shared package `aes_pkg`: `N`, `Nr`, the `RCON` array {01,02,04,08,10,20,40,80,1b,36}, and the FSM state enum typedef.
- One sub-module `aes_sbox`: combinational 8-bit forward S-box, instantiated 4× for SubWord. It is reusable by the sub-bytes stage.
- Layout helpers (word ↔ flat byte mapping) are functions in `aes_pkg`.

## Test plan
- FIPS-197 A.1 key `2b7e1516 28aed2a6 abf71588 09cf4f3c` with `rk_ready=1`:
  - round 0 equals the key;
  - round 1 is `a0fafe17 88542cb1 23a33939 2a6c7605`;
  - round 10 is `d014f9a8 c9ee2589 e13f0cc8 b6630ca6` with `rk_last=1`;
  - `start_ready=1` on the next cycle.
- All-zero key: round 1 = `62636363` ×4 words, `rk_round=1`.
- Backpressure: drop `rk_ready` for 5 cycles while round 3 is presented. `rk`, `rk_round=3` and `rk_valid=1` stay unchanged, and round 4 follows one cycle after `rk_ready` returns.
- `start_valid` pulsed with a different key during round 2 of the A.1 key: ignored, and the A.1 sequence completes unchanged.
- `rst` asserted one cycle while round 5 is presented: `rk_valid=0` and `start_ready=1` afterward. A new A.1 key then yields round 0 at accept+1.
- With `AES_KEY_REVERSE_EN` and `decrypt=1` on the A.1 key:
  - `rk_valid` is 0 for 10 cycles;
  - round 10 `d014f9a8…` appears at accept+11, then rounds count down;
  - round 0 equals the key, with `rk_last=1`.
